mem_lsu: RTL and testbench

//  Memory-stage load/store unit: the responder end of the exe->mem memory-op interface.

---
 rtl/mem_lsu_pkg.sv | 49 ++++
 rtl/mem_lsu_if.sv | 31 +++
 rtl/mem_lsu_align.sv | 91 +++++++++
 rtl/mem_lsu.sv | 182 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared types, bus widths and op-class helpers for mem_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_BW = BUS_DW / 8;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_if.sv
// ============================================================================
// Module      : mem_lsu_if
// Description : Data-bus request/response bundle between the LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_lsu_if;

    logic                               bus_req_out;
    logic                               bus_we_out;
    logic [mem_lsu_pkg::BUS_AW-1:0]     bus_addr_out;
    logic [mem_lsu_pkg::BUS_BW-1:0]     bus_be_out;
    logic [mem_lsu_pkg::BUS_DW-1:0]     bus_wdata_out;
    logic                               bus_gnt_in;
    logic                               bus_rvalid_in;
    logic [mem_lsu_pkg::BUS_DW-1:0]     bus_rdata_in;

    modport master (
        output bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
        input  bus_gnt_in, bus_rvalid_in, bus_rdata_in
    );

    modport slave (
        input  bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
        output bus_gnt_in, bus_rvalid_in, bus_rdata_in
    );

endinterface

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// ============================================================================
// Module      : mem_lsu_align
// Description : Byte-lane enables, store replication, misalign detect, load extend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  wire logic [3:0]         op_i,
    input  wire logic [1:0]         addr_lo_i,
    input  wire logic [BUS_DW-1:0]  sdata_i,
    input  wire logic [BUS_DW-1:0]  rword_i,
    output logic      [BUS_BW-1:0]  be_o,
    output logic      [BUS_DW-1:0]  wdata_o,
    output logic                    misalign_o,
    output logic      [BUS_DW-1:0]  ldata_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be_byte;
    logic [3:0]  w_be_half;

    always_comb begin
        case (addr_lo_i)
            2'd0:    w_byte = rword_i[7:0];
            2'd1:    w_byte = rword_i[15:8];
            2'd2:    w_byte = rword_i[23:16];
            default: w_byte = rword_i[31:24];
        endcase
    end

    assign w_half    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    assign w_be_byte = 4'b0001 << addr_lo_i;
    assign w_be_half = addr_lo_i[1] ? 4'b1100 : 4'b0011;

    // Loads drive the same lane enables as a store of the same width.
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = sdata_i;
        misalign_o = 1'b0;
        ldata_o    = '0;
        case (op_i)
            MEM_LB: begin
                be_o    = w_be_byte;
                ldata_o = {{24{w_byte[7]}}, w_byte};
            end
            MEM_LBU: begin
                be_o    = w_be_byte;
                ldata_o = {24'd0, w_byte};
            end
            MEM_LH: begin
                be_o       = w_be_half;
                misalign_o = addr_lo_i[0];
                ldata_o    = {{16{w_half[15]}}, w_half};
            end
            MEM_LHU: begin
                be_o       = w_be_half;
                misalign_o = addr_lo_i[0];
                ldata_o    = {16'd0, w_half};
            end
            MEM_LW: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
                ldata_o    = rword_i;
            end
            MEM_SB: begin
                be_o    = w_be_byte;
                wdata_o = {4{sdata_i[7:0]}};
            end
            MEM_SH: begin
                be_o       = w_be_half;
                misalign_o = addr_lo_i[0];
                wdata_o    = {2{sdata_i[15:0]}};
            end
            MEM_SW: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
                wdata_o    = sdata_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : Memory-stage load/store unit; one data-bus transaction per op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  wire logic               clk_in,
    input  wire logic               reset_in,
    input  wire logic [3:0]         mem_op_in,
    input  wire logic [BUS_AW-1:0]  mem_addr_in,
    input  wire logic [BUS_DW-1:0]  mem_data_in,
    input  wire logic               mem_we_in,
    input  wire logic [4:0]         reg_waddr_in,
    input  wire logic [31:0]        reg_wdata_in,
    input  wire logic               reg_we_in,
    input  wire logic               hold_in,
    mem_lsu_if.master               bus,
    output logic      [4:0]         reg_waddr_out,
    output logic      [31:0]        reg_wdata_out,
    output logic                    reg_we_out,
    output logic                    stall_req_out,
    output logic                    misalign_out,
    output logic                    bus_err_out
);

    localparam int               CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic             TO_EN   = (TIMEOUT_CYCLES > 0);

    lsu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ldata_q, ldata_d;
    logic               done_we_q, done_we_d;

    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_mem;
    logic               w_misalign_det;
    logic [BUS_BW-1:0]  w_be;
    logic [BUS_DW-1:0]  w_wdata;
    logic [31:0]        w_ldata;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    lsu_state_e         w_fin;

    logic               w_req;
    logic               w_req_o;
    logic               w_stall;
    logic               w_wb_we;
    logic [31:0]        w_wb_data;
    logic               w_misalign;
    logic               w_err;
    logic               w_unused_we;

    // The op code alone decides the access class; the store flag is redundant.
    assign w_unused_we = mem_we_in;

    assign w_is_load  = op_is_load(mem_op_in);
    assign w_is_store = op_is_store(mem_op_in);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_cnt_inc  = TO_EN ? (cnt_q + CNT_W'(1)) : '0;
    assign w_timeout  = TO_EN && (cnt_q >= CNT_MAX);
    assign w_fin      = hold_in ? ST_DONE : ST_IDLE;

    mem_lsu_align u_align (
        .op_i       (mem_op_in),
        .addr_lo_i  (mem_addr_in[1:0]),
        .sdata_i    (mem_data_in),
        .rword_i    (bus.bus_rdata_in),
        .be_o       (w_be),
        .wdata_o    (w_wdata),
        .misalign_o (w_misalign_det),
        .ldata_o    (w_ldata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ldata_d    = ldata_q;
        done_we_d  = done_we_q;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_wb_we    = 1'b0;
        w_wb_data  = reg_wdata_in;
        w_misalign = 1'b0;
        w_err      = 1'b0;
        case (state_q)
            ST_IDLE, ST_REQ: begin
                if (state_q == ST_IDLE && !w_is_mem) begin
                    w_wb_we = reg_we_in;
                end else if (state_q == ST_IDLE && w_misalign_det) begin
                    w_misalign = 1'b1;
                    done_we_d  = 1'b0;
                    state_d    = w_fin;
                end else if (state_q == ST_REQ && w_timeout) begin
                    w_err     = 1'b1;
                    cnt_d     = '0;
                    done_we_d = 1'b0;
                    state_d   = w_fin;
                end else begin
                    w_req = 1'b1;
                    if (bus.bus_gnt_in && w_is_store) begin
                        cnt_d     = '0;
                        done_we_d = 1'b0;
                        state_d   = w_fin;
                    end else begin
                        w_stall = 1'b1;
                        cnt_d   = w_cnt_inc;
                        state_d = bus.bus_gnt_in ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_WAIT: begin
                if (w_timeout) begin
                    w_err     = 1'b1;
                    cnt_d     = '0;
                    done_we_d = 1'b0;
                    state_d   = w_fin;
                end else if (bus.bus_rvalid_in) begin
                    w_wb_data = w_ldata;
                    w_wb_we   = reg_we_in;
                    ldata_d   = w_ldata;
                    done_we_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = w_fin;
                end else begin
                    w_stall = 1'b1;
                    cnt_d   = w_cnt_inc;
                end
            end
            ST_DONE: begin
                w_wb_data = ldata_q;
                w_wb_we   = done_we_q & reg_we_in;
                if (!hold_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ldata_q   <= '0;
            done_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ldata_q   <= ldata_d;
            done_we_q <= done_we_d;
        end
    end

    // Request and writeback paths are combinational, so reset must mask them.
    assign w_req_o            = w_req & ~reset_in;
    assign bus.bus_req_out    = w_req_o;
    assign bus.bus_we_out     = w_req_o & w_is_store;
    assign bus.bus_addr_out   = w_req_o ? {mem_addr_in[BUS_AW-1:2], 2'b00} : '0;
    assign bus.bus_be_out     = w_req_o ? w_be : '0;
    assign bus.bus_wdata_out  = (w_req_o && w_is_store) ? w_wdata : '0;

    assign reg_waddr_out = reset_in ? 5'd0  : reg_waddr_in;
    assign reg_wdata_out = reset_in ? 32'd0 : w_wb_data;
    assign reg_we_out    = w_wb_we    & ~reset_in;
    assign stall_req_out = w_stall    & ~reset_in;
    assign misalign_out  = w_misalign & ~reset_in;
    assign bus_err_out   = w_err      & ~reset_in;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module      : tb_mem_lsu
// Description : Directed scoreboard bench for mem_lsu (main and short-timeout DUT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;
    import mem_lsu_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_item_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [3:0]  mem_op_in;
    logic [3:0]  op_to;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_data_in;
    logic        mem_we_in;
    logic [4:0]  reg_waddr_in;
    logic [31:0] reg_wdata_in;
    logic        reg_we_in;
    logic        hold_in;

    logic [4:0]  reg_waddr_out, to_waddr;
    logic [31:0] reg_wdata_out, to_wdata;
    logic        reg_we_out, stall_req_out, misalign_out, bus_err_out;
    logic        to_we, to_stall, to_misalign, to_err;

    mem_lsu_if bus();
    mem_lsu_if bus_to();

    bus_item_t   bus_exp_q[$];
    logic [31:0] wb_exp_q[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    always #5 clk_in = ~clk_in;

    mem_lsu dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .mem_op_in     (mem_op_in),
        .mem_addr_in   (mem_addr_in),
        .mem_data_in   (mem_data_in),
        .mem_we_in     (mem_we_in),
        .reg_waddr_in  (reg_waddr_in),
        .reg_wdata_in  (reg_wdata_in),
        .reg_we_in     (reg_we_in),
        .hold_in       (hold_in),
        .bus           (bus),
        .reg_waddr_out (reg_waddr_out),
        .reg_wdata_out (reg_wdata_out),
        .reg_we_out    (reg_we_out),
        .stall_req_out (stall_req_out),
        .misalign_out  (misalign_out),
        .bus_err_out   (bus_err_out)
    );

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .mem_op_in     (op_to),
        .mem_addr_in   (mem_addr_in),
        .mem_data_in   (mem_data_in),
        .mem_we_in     (mem_we_in),
        .reg_waddr_in  (reg_waddr_in),
        .reg_wdata_in  (reg_wdata_in),
        .reg_we_in     (reg_we_in),
        .hold_in       (hold_in),
        .bus           (bus_to),
        .reg_waddr_out (to_waddr),
        .reg_wdata_out (to_wdata),
        .reg_we_out    (to_we),
        .stall_req_out (to_stall),
        .misalign_out  (to_misalign),
        .bus_err_out   (to_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bus_item_t mk_bus(input logic we, input logic [31:0] addr,
                                         input logic [3:0] be, input logic [31:0] wdata);
        bus_item_t it;
        it.we    = we;
        it.addr  = addr;
        it.be    = be;
        it.wdata = wdata;
        return it;
    endfunction

    task automatic chk_bus(input string tag);
        bus_item_t e;
        chk({tag, "_sb_depth"}, 32'(bus_exp_q.size()), 32'd1);
        if (bus_exp_q.size() > 0) begin
            e = bus_exp_q.pop_front();
            chk({tag, "_req"},   32'(bus.bus_req_out), 32'd1);
            chk({tag, "_we"},    32'(bus.bus_we_out), 32'(e.we));
            chk({tag, "_addr"},  bus.bus_addr_out, e.addr);
            chk({tag, "_be"},    32'(bus.bus_be_out), 32'(e.be));
            chk({tag, "_wdata"}, bus.bus_wdata_out, e.wdata);
        end
    endtask

    task automatic chk_wb(input string tag);
        logic [31:0] e;
        chk({tag, "_wb_depth"}, 32'(wb_exp_q.size()), 32'd1);
        if (wb_exp_q.size() > 0) begin
            e = wb_exp_q.pop_front();
            chk({tag, "_wb_data"}, reg_wdata_out, e);
            chk({tag, "_wb_we"},   32'(reg_we_out), 32'd1);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic samp();
        @(negedge clk_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in     = 1'b1;
        mem_op_in    = MEM_NOP;
        op_to        = MEM_NOP;
        mem_addr_in  = 32'd0;
        mem_data_in  = 32'd0;
        mem_we_in    = 1'b0;
        reg_waddr_in = 5'd7;
        reg_wdata_in = 32'hA5A5A5A5;
        reg_we_in    = 1'b1;
        hold_in      = 1'b0;
        bus.bus_gnt_in       = 1'b0;
        bus.bus_rvalid_in    = 1'b0;
        bus.bus_rdata_in     = 32'd0;
        bus_to.bus_gnt_in    = 1'b0;
        bus_to.bus_rvalid_in = 1'b0;
        bus_to.bus_rdata_in  = 32'd0;

        // Reset: every output low even with pass-through inputs active
        step(); step(); samp();
        chk("rst_req",      32'(bus.bus_req_out), 32'd0);
        chk("rst_we",       32'(reg_we_out), 32'd0);
        chk("rst_wdata",    reg_wdata_out, 32'd0);
        chk("rst_stall",    32'(stall_req_out), 32'd0);
        chk("rst_to_wdata", to_wdata, 32'd0);
        chk("rst_to_waddr", 32'(to_waddr), 32'd0);

        // NOP pass-through
        step(); reset_in = 1'b0; samp();
        chk("nop_wdata", reg_wdata_out, 32'hA5A5A5A5);
        chk("nop_waddr", 32'(reg_waddr_out), 32'd7);
        chk("nop_we",    32'(reg_we_out), 32'd1);
        chk("nop_req",   32'(bus.bus_req_out), 32'd0);

        // SW, granted in the issue cycle
        step();
        mem_op_in = MEM_SW; mem_addr_in = 32'h100; mem_data_in = 32'hDEADBEEF;
        mem_we_in = 1'b1; bus.bus_gnt_in = 1'b1;
        bus_exp_q.push_back(mk_bus(1'b1, 32'h100, 4'hF, 32'hDEADBEEF));
        samp();
        chk_bus("sw");
        chk("sw_stall", 32'(stall_req_out), 32'd0);
        chk("sw_regwe", 32'(reg_we_out), 32'd0);
        step(); mem_op_in = MEM_NOP; mem_we_in = 1'b0; bus.bus_gnt_in = 1'b0; samp();
        chk("sw_after_stall", 32'(stall_req_out), 32'd0);
        chk("sw_after_idle",  32'(reg_we_out), 32'd1);

        // SB lane replication
        step();
        mem_op_in = MEM_SB; mem_addr_in = 32'h102; mem_data_in = 32'h123456AB;
        mem_we_in = 1'b1; bus.bus_gnt_in = 1'b1;
        bus_exp_q.push_back(mk_bus(1'b1, 32'h100, 4'b0100, 32'hABABABAB));
        samp();
        chk_bus("sb");
        step(); mem_op_in = MEM_NOP; mem_we_in = 1'b0; bus.bus_gnt_in = 1'b0; mem_data_in = 32'd0;

        // LB 0x103: grant in cycle 0, rvalid in cycle 2
        mem_op_in = MEM_LB; mem_addr_in = 32'h103; reg_waddr_in = 5'd3; bus.bus_gnt_in = 1'b1;
        bus_exp_q.push_back(mk_bus(1'b0, 32'h100, 4'b1000, 32'd0));
        wb_exp_q.push_back(32'hFFFFFF80);
        samp();
        chk_bus("lb");
        chk("lb_stall0", 32'(stall_req_out), 32'd1);
        step(); bus.bus_gnt_in = 1'b0; samp();
        chk("lb_stall1", 32'(stall_req_out), 32'd1);
        chk("lb_req1",   32'(bus.bus_req_out), 32'd0);
        chk("lb_we1",    32'(reg_we_out), 32'd0);
        step(); bus.bus_rvalid_in = 1'b1; bus.bus_rdata_in = 32'h80112233; samp();
        chk_wb("lb");
        chk("lb_stall2", 32'(stall_req_out), 32'd0);
        chk("lb_waddr",  32'(reg_waddr_out), 32'd3);
        step(); bus.bus_rvalid_in = 1'b0; mem_op_in = MEM_NOP;

        // LHU 0x102: grant after three request cycles
        mem_op_in = MEM_LHU; mem_addr_in = 32'h102;
        bus_exp_q.push_back(mk_bus(1'b0, 32'h100, 4'b1100, 32'd0));
        wb_exp_q.push_back(32'h0000BEEF);
        samp();
        chk("lhu_req0",   32'(bus.bus_req_out), 32'd1);
        chk("lhu_stall0", 32'(stall_req_out), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(); samp();
            chk("lhu_req_held",    32'(bus.bus_req_out), 32'd1);
            chk("lhu_addr_stable", bus.bus_addr_out, 32'h100);
            chk("lhu_be_stable",   32'(bus.bus_be_out), 32'hC);
            chk("lhu_stall_req",   32'(stall_req_out), 32'd1);
        end
        step(); bus.bus_gnt_in = 1'b1; samp();
        chk_bus("lhu");
        chk("lhu_stall_gnt", 32'(stall_req_out), 32'd1);
        step(); bus.bus_gnt_in = 1'b0; bus.bus_rvalid_in = 1'b1; bus.bus_rdata_in = 32'hBEEF1234; samp();
        chk_wb("lhu");
        chk("lhu_stall_done", 32'(stall_req_out), 32'd0);
        step(); bus.bus_rvalid_in = 1'b0; mem_op_in = MEM_NOP;

        // SH to an odd address is dropped
        mem_op_in = MEM_SH; mem_addr_in = 32'h101; mem_data_in = 32'h00005555; mem_we_in = 1'b1;
        samp();
        chk("sh_mis_pulse", 32'(misalign_out), 32'd1);
        chk("sh_mis_req",   32'(bus.bus_req_out), 32'd0);
        chk("sh_mis_we",    32'(reg_we_out), 32'd0);
        chk("sh_mis_stall", 32'(stall_req_out), 32'd0);
        step(); mem_op_in = MEM_NOP; mem_we_in = 1'b0; samp();
        chk("sh_mis_clear", 32'(misalign_out), 32'd0);

        // LW completing under hold_in: result held in DONE, no new request
        step();
        mem_op_in = MEM_LW; mem_addr_in = 32'h200; hold_in = 1'b1; bus.bus_gnt_in = 1'b1;
        bus_exp_q.push_back(mk_bus(1'b0, 32'h200, 4'hF, 32'd0));
        wb_exp_q.push_back(32'hCAFEF00D);
        samp();
        chk_bus("lw");
        step(); bus.bus_gnt_in = 1'b0; bus.bus_rvalid_in = 1'b1; bus.bus_rdata_in = 32'hCAFEF00D; samp();
        chk_wb("lw");
        chk("lw_stall_done", 32'(stall_req_out), 32'd0);
        step(); bus.bus_rvalid_in = 1'b0; bus.bus_rdata_in = 32'd0; bus.bus_gnt_in = 1'b1; samp();
        chk("lw_done_data",  reg_wdata_out, 32'hCAFEF00D);
        chk("lw_done_we",    32'(reg_we_out), 32'd1);
        chk("lw_done_req",   32'(bus.bus_req_out), 32'd0);
        chk("lw_done_stall", 32'(stall_req_out), 32'd0);
        step(); hold_in = 1'b0; samp();
        chk("lw_release_req",  32'(bus.bus_req_out), 32'd0);
        chk("lw_release_data", reg_wdata_out, 32'hCAFEF00D);
        step(); mem_op_in = MEM_NOP; bus.bus_gnt_in = 1'b0; samp();
        chk("lw_back_idle", reg_wdata_out, 32'hA5A5A5A5);

        // Reset in the middle of a load's WAIT phase; late rvalid ignored
        step();
        mem_op_in = MEM_LW; mem_addr_in = 32'h300; bus.bus_gnt_in = 1'b1;
        bus_exp_q.push_back(mk_bus(1'b0, 32'h300, 4'hF, 32'd0));
        samp();
        chk_bus("lwr");
        step(); bus.bus_gnt_in = 1'b0; samp();
        chk("lwr_wait_stall", 32'(stall_req_out), 32'd1);
        step(); reset_in = 1'b1; samp();
        chk("lwr_rst_req",   32'(bus.bus_req_out), 32'd0);
        chk("lwr_rst_stall", 32'(stall_req_out), 32'd0);
        chk("lwr_rst_we",    32'(reg_we_out), 32'd0);
        chk("lwr_rst_wdata", reg_wdata_out, 32'd0);
        step();
        reset_in = 1'b0; mem_op_in = MEM_NOP; reg_we_in = 1'b0;
        bus.bus_rvalid_in = 1'b1; bus.bus_rdata_in = 32'h11111111;
        samp();
        chk("lwr_late_we",    32'(reg_we_out), 32'd0);
        chk("lwr_late_wdata", reg_wdata_out, 32'hA5A5A5A5);
        chk("lwr_late_stall", 32'(stall_req_out), 32'd0);
        step(); bus.bus_rvalid_in = 1'b0; reg_we_in = 1'b1;

        // Timeout of 4 cycles with the grant never arriving
        op_to = MEM_LW; mem_addr_in = 32'h400;
        samp();
        chk("to_req0",   32'(bus_to.bus_req_out), 32'd1);
        chk("to_addr0",  bus_to.bus_addr_out, 32'h400);
        chk("to_be0",    32'(bus_to.bus_be_out), 32'hF);
        chk("to_we0",    32'(bus_to.bus_we_out), 32'd0);
        chk("to_wdata0", bus_to.bus_wdata_out, 32'd0);
        chk("to_stall0", 32'(to_stall), 32'd1);
        chk("to_err0",   32'(to_err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(); samp();
            chk("to_req_wait",   32'(bus_to.bus_req_out), 32'd1);
            chk("to_stall_wait", 32'(to_stall), 32'd1);
            chk("to_err_wait",   32'(to_err), 32'd0);
        end
        step(); samp();
        chk("to_err_pulse", 32'(to_err), 32'd1);
        chk("to_req_drop",  32'(bus_to.bus_req_out), 32'd0);
        chk("to_stall_end", 32'(to_stall), 32'd0);
        chk("to_regwe",     32'(to_we), 32'd0);
        chk("to_misalign",  32'(to_misalign), 32'd0);
        step(); op_to = MEM_NOP; samp();
        chk("to_err_clear", 32'(to_err), 32'd0);

        chk("sb_bus_empty", 32'(bus_exp_q.size()), 32'd0);
        chk("sb_wb_empty",  32'(wb_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
